// File: rtl/slc3_pkg.sv
// Shared definitions for the SRAM access controller: FSM encoding and
// the default strobe width.
package slc3_pkg;

  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WSETUP = 3'd2,
    ST_WPULSE = 3'd3,
    ST_WHOLD  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // States during which the SRAM chip is selected.
  function automatic logic is_access(state_t s);
    return (s == ST_RD) || (s == ST_WSETUP) || (s == ST_WPULSE) || (s == ST_WHOLD);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Strobe-width counter: reloads on entry to a timed state and counts down,
// saturating at zero so it never wraps.
module wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Asynchronous SRAM access controller: one read or write per request with
// programmable strobe width and a one-cycle ready pulse.
module mem_access_ctrl
  import slc3_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        rw,
  input  logic [19:0] addr,
  input  logic [15:0] wdata,
  input  logic [1:0]  be,
  output logic        ready,
  output logic [15:0] rdata,
  output logic [19:0] A,
  output logic        CE,
  output logic        OE,
  output logic        WE,
  output logic        UB,
  output logic        LB,
  input  logic [15:0] mem_din,
  output logic [15:0] mem_dout,
  output logic        mem_dout_en,
  output logic [2:0]  state_dbg
);

  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [1:0] be_q;
  logic       rd_q;
  logic       wait_zero;
  logic       cnt_load;
  logic       cnt_en;
  logic       in_access;

  assign in_access = is_access(state);
  assign state_dbg = state;

  assign cnt_load = ((state == ST_IDLE) && req && !rw && (be != 2'b00)) ||
                    (state == ST_WSETUP);
  assign cnt_en   = (state == ST_RD) || (state == ST_WPULSE);

  wait_counter u_wait (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (RELOAD),
    .zero     (wait_zero)
  );

  // Outputs are registered decodes of the current state, so every pin
  // trails the state register by one cycle; this puts the last OE-low
  // cycle on the same edge that enters DONE's ready phase, where rdata
  // is captured.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      CE          <= 1'b1;
      OE          <= 1'b1;
      WE          <= 1'b1;
      UB          <= 1'b1;
      LB          <= 1'b1;
      ready       <= 1'b0;
      mem_dout_en <= 1'b0;
      A           <= 20'd0;
      rdata       <= 16'd0;
      mem_dout    <= 16'd0;
      be_q        <= 2'b00;
      rd_q        <= 1'b0;
    end else begin
      CE          <= !in_access;
      OE          <= !(state == ST_RD);
      WE          <= !(state == ST_WPULSE);
      UB          <= !(in_access && be_q[1]);
      LB          <= !(in_access && be_q[0]);
      mem_dout_en <= (state == ST_WSETUP) || (state == ST_WPULSE) || (state == ST_WHOLD);
      ready       <= (state == ST_DONE);

      if ((state == ST_DONE) && rd_q) begin
        rdata <= mem_din;
      end

      case (state)
        ST_IDLE: begin
          if (req) begin
            A        <= addr;
            mem_dout <= wdata;
            be_q     <= be;
            rd_q     <= !rw && (be != 2'b00);
            if (be == 2'b00) begin
              state <= ST_DONE;
            end else if (rw) begin
              state <= ST_WSETUP;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (wait_zero) begin
            state <= ST_DONE;
          end
        end
        ST_WSETUP: state <= ST_WPULSE;
        ST_WPULSE: begin
          if (wait_zero) begin
            state <= ST_WHOLD;
          end
        end
        ST_WHOLD: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with WAIT_CYCLES=2 and a small SRAM
// read model that only drives valid data while CE and OE are low.
module tb_mem_access_ctrl;
  import slc3_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        req;
  logic        rw;
  logic [19:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        ready;
  logic [15:0] rdata;
  logic [19:0] A;
  logic        CE, OE, WE, UB, LB;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_dout_en;
  logic [2:0]  state_dbg;

  logic [15:0] rd_val;
  int checks;
  int failures;
  int violations;

  assign mem_din = (!CE && !OE) ? rd_val : 16'hDEAD;

  mem_access_ctrl #(.WAIT_CYCLES(2)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req         (req),
    .rw          (rw),
    .addr        (addr),
    .wdata       (wdata),
    .be          (be),
    .ready       (ready),
    .rdata       (rdata),
    .A           (A),
    .CE          (CE),
    .OE          (OE),
    .WE          (WE),
    .UB          (UB),
    .LB          (LB),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mem_dout_en (mem_dout_en),
    .state_dbg   (state_dbg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if ((!OE && !WE) || (mem_dout_en && !OE)) begin
      violations++;
      $display("FAIL strobe_overlap t=%0t OE=%b WE=%b mem_dout_en=%b required no overlap",
               $time, OE, WE, mem_dout_en);
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if ({CE, OE, WE, UB, LB} !== 5'b11111) begin
      failures++;
      $display("FAIL reset_strobes got=%b required=11111", {CE, OE, WE, UB, LB});
    end
    checks++;
    if (ready !== 1'b0 || mem_dout_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_en got=%b%b required=00", ready, mem_dout_en);
    end
    checks++;
    if (A !== 20'd0 || rdata !== 16'd0 || mem_dout !== 16'd0) begin
      failures++;
      $display("FAIL reset_data A=%h rdata=%h mem_dout=%h required zeros", A, rdata, mem_dout);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d required=%0d", state_dbg, ST_IDLE);
    end
    tick;
    tick;
    Reset = 1'b1;
    tick;
  endtask

  task automatic test_read;
    int oe_cnt;
    int rdy_cnt;
    int rdy_at;
    req = 1'b1; rw = 1'b0; addr = 20'h00012; be = 2'b11; rd_val = 16'hBEEF;
    tick;
    req = 1'b0; addr = 20'h0;
    checks++;
    if (A !== 20'h00012) begin
      failures++;
      $display("FAIL read_addr got=%h required=00012", A);
    end
    oe_cnt = 0; rdy_cnt = 0; rdy_at = -1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      if (!OE) oe_cnt++;
      if (ready) begin
        rdy_cnt++;
        if (rdy_at < 0) begin
          rdy_at = i;
          checks++;
          if (rdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL read_data got=%h required=beef", rdata);
          end
        end
      end
    end
    checks++;
    if (oe_cnt != 2) begin
      failures++;
      $display("FAIL read_oe_width got=%0d required=2", oe_cnt);
    end
    checks++;
    if (rdy_at != 3 || rdy_cnt != 1) begin
      failures++;
      $display("FAIL read_latency got_at=%0d got_pulses=%0d required_at=3 pulses=1", rdy_at, rdy_cnt);
    end
    checks++;
    if (rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL read_hold got=%h required=beef", rdata);
    end
  endtask

  task automatic test_write;
    int we_cnt;
    int en_cnt;
    int we_outside;
    int lane_bad;
    int dout_bad;
    int rdy_at;
    req = 1'b1; rw = 1'b1; addr = 20'h00034; wdata = 16'h1234; be = 2'b10;
    tick;
    req = 1'b0; wdata = 16'hFFFF; be = 2'b01;
    we_cnt = 0; en_cnt = 0; we_outside = 0; lane_bad = 0; dout_bad = 0; rdy_at = -1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      if (!WE) we_cnt++;
      if (mem_dout_en) en_cnt++;
      if (!WE && !mem_dout_en) we_outside++;
      if (!CE && (UB !== 1'b0 || LB !== 1'b1 || A !== 20'h00034)) lane_bad++;
      if (mem_dout_en && mem_dout !== 16'h1234) dout_bad++;
      if (ready && rdy_at < 0) rdy_at = i;
    end
    checks++;
    if (we_cnt != 2 || we_outside != 0) begin
      failures++;
      $display("FAIL write_we_width got=%0d outside=%0d required=2 outside=0", we_cnt, we_outside);
    end
    checks++;
    if (en_cnt != 4) begin
      failures++;
      $display("FAIL write_en_window got=%0d required=4", en_cnt);
    end
    checks++;
    if (lane_bad != 0 || dout_bad != 0) begin
      failures++;
      $display("FAIL write_lanes lane_bad=%0d dout_bad=%0d required=0", lane_bad, dout_bad);
    end
    checks++;
    if (rdy_at != 5) begin
      failures++;
      $display("FAIL write_latency got=%0d required=5", rdy_at);
    end
  endtask

  task automatic test_no_bytes;
    int strobe_cnt;
    int rdy_at;
    req = 1'b1; rw = 1'b0; addr = 20'h00077; be = 2'b00; rd_val = 16'h0BAD;
    tick;
    req = 1'b0;
    strobe_cnt = 0; rdy_at = -1;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (!CE || !OE || !WE || !UB || !LB) strobe_cnt++;
      if (ready && rdy_at < 0) rdy_at = i;
    end
    checks++;
    if (strobe_cnt != 0) begin
      failures++;
      $display("FAIL nobe_strobes got=%0d required=0", strobe_cnt);
    end
    checks++;
    if (rdy_at != 1) begin
      failures++;
      $display("FAIL nobe_latency got=%0d required=1", rdy_at);
    end
    checks++;
    if (rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL nobe_rdata got=%h required=beef", rdata);
    end
  endtask

  task automatic test_back_to_back;
    int rdy_cnt;
    int first_at;
    int second_at;
    logic [19:0] a3;
    logic [19:0] a5;
    req = 1'b1; rw = 1'b0; addr = 20'h00100; be = 2'b11; rd_val = 16'h5555;
    tick;
    addr = 20'h00200;
    rdy_cnt = 0; first_at = -1; second_at = -1; a3 = '0; a5 = '0;
    for (int i = 1; i <= 7; i++) begin
      tick;
      if (i == 3) a3 = A;
      if (i == 5) a5 = A;
      if (ready) begin
        rdy_cnt++;
        if (first_at < 0) first_at = i;
        else second_at = i;
      end
    end
    req = 1'b0;
    tick;
    tick;
    checks++;
    if (rdy_cnt != 2 || first_at != 3 || second_at != 7) begin
      failures++;
      $display("FAIL b2b_ready count=%0d at=%0d,%0d required 2 at 3,7", rdy_cnt, first_at, second_at);
    end
    checks++;
    if (a3 !== 20'h00100 || a5 !== 20'h00200) begin
      failures++;
      $display("FAIL b2b_addr got=%h,%h required=00100,00200", a3, a5);
    end
    checks++;
    if (rdata !== 16'h5555) begin
      failures++;
      $display("FAIL b2b_rdata got=%h required=5555", rdata);
    end
  endtask

  task automatic test_reset_mid_write;
    int rdy_cnt;
    int rdy_at;
    req = 1'b1; rw = 1'b1; addr = 20'h00abc; wdata = 16'hA5A5; be = 2'b11;
    tick;
    req = 1'b0;
    tick;
    tick;
    checks++;
    if (WE !== 1'b0) begin
      failures++;
      $display("FAIL abort_pre_we got=%b required=0", WE);
    end
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (WE !== 1'b1 || mem_dout_en !== 1'b0 || CE !== 1'b1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs WE=%b en=%b CE=%b ready=%b required 1,0,1,0", WE, mem_dout_en, CE, ready);
    end
    tick;
    Reset = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (ready) rdy_cnt++;
    end
    checks++;
    if (rdy_cnt != 0) begin
      failures++;
      $display("FAIL abort_no_ready got=%0d required=0", rdy_cnt);
    end
    req = 1'b1; rw = 1'b0; addr = 20'h00055; be = 2'b11; rd_val = 16'hCAFE;
    tick;
    req = 1'b0;
    rdy_at = -1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (ready && rdy_at < 0) rdy_at = i;
    end
    checks++;
    if (rdy_at != 3 || rdata !== 16'hCAFE) begin
      failures++;
      $display("FAIL abort_recover at=%0d rdata=%h required at=3 rdata=cafe", rdy_at, rdata);
    end
  endtask

  initial begin
    checks = 0; failures = 0; violations = 0;
    req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; be = '0; rd_val = '0;
    test_reset;
    test_read;
    test_write;
    test_no_bytes;
    test_back_to_back;
    test_reset_mid_write;
    checks++;
    if (violations != 0) begin
      failures++;
      $display("FAIL strobe_exclusion got=%0d required=0", violations);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
